// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver: frame geometry, counter
// width default and the receive state encoding.
package serial_word_receiver_pkg;

    localparam int DEF_WORD_BITS = 16;
    localparam int DEF_CNT_W     = 8;
    localparam int BIT_CNT_W     = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

endpackage : serial_word_receiver_pkg

// File: rtl/serial_word_receiver_sticky_flag.sv
// Set/clear status register; a set and a clear on the same edge leave the
// flag set so a fault is never lost to a concurrent acknowledge.
module serial_word_receiver_sticky_flag (
    input  logic data_clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic flag
);

    logic flag_q, flag_d;

    always_comb begin
        flag_d = flag_q;
        if (set) begin
            flag_d = 1'b1;
        end else if (clr) begin
            flag_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge data_clk or posedge reset) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule : serial_word_receiver_sticky_flag

// File: rtl/serial_word_receiver.sv
// Assembles MSB-first serial bits into words delimited by frame_sync, strobes
// read for one cycle per completed word, flags early syncs and counts words.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WORD_BITS = DEF_WORD_BITS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 data_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sdata_in,
    input  logic                 frame_sync,
    input  logic                 err_clr,
    output logic [WORD_BITS-1:0] data16,
    output logic                 read,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     word_cnt
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_BITS - 1);

    rx_state_e              state_q, state_d;
    logic [WORD_BITS-2:0]   shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]   data16_q, data16_d;
    logic                   read_q, read_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;

    logic sync_start;
    logic early_sync;
    logic last_bit;
    logic shifting;

    // Every frame_sync seen while shifting is early: bit_cnt is always 1..15 there.
    assign sync_start = (state_q == ST_IDLE)  && enable && frame_sync;
    assign early_sync = (state_q == ST_SHIFT) && enable && frame_sync;
    assign last_bit   = (state_q == ST_SHIFT) && enable && !frame_sync
                        && (bit_cnt_q == LAST_BIT);
    assign shifting   = (state_q == ST_SHIFT) && enable && !frame_sync
                        && (bit_cnt_q != LAST_BIT);

    always_ff @(posedge data_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sync_start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!enable || last_bit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        data16_d   = data16_q;
        read_d     = 1'b0;
        word_cnt_d = word_cnt_q;
        if (sync_start || early_sync) begin
            shreg_d   = {{(WORD_BITS-2){1'b0}}, sdata_in};
            bit_cnt_d = BIT_CNT_W'(1);
        end else if (last_bit) begin
            data16_d   = {shreg_q, sdata_in};
            read_d     = 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
            bit_cnt_d  = '0;
        end else if (shifting) begin
            shreg_d   = {shreg_q[WORD_BITS-3:0], sdata_in};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge data_clk or posedge reset) begin
        if (reset) begin
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            data16_q   <= '0;
            read_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            data16_q   <= data16_d;
            read_q     <= read_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    serial_word_receiver_sticky_flag u_frame_err (
        .data_clk (data_clk),
        .reset    (reset),
        .set      (early_sync),
        .clr      (err_clr),
        .flag     (frame_err)
    );

    assign data16   = data16_q;
    assign read     = read_q;
    assign word_cnt = word_cnt_q;

endmodule : serial_word_receiver

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: expected words are queued when a
// frame is driven and compared whenever the receiver strobes read.
module tb_serial_word_receiver;

    logic        data_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic        sdata_in = 1'b0;
    logic        frame_sync = 1'b0;
    logic        err_clr  = 1'b0;
    logic [15:0] data16;
    logic        read;
    logic        frame_err;
    logic [7:0]  word_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int reads_seen = 0;
    int last_read_cyc = 0;
    int read_gap  = 0;
    int reads0;
    logic prev_read = 1'b0;
    logic [15:0] sb[$];

    serial_word_receiver dut (
        .data_clk   (data_clk),
        .reset      (reset),
        .enable     (enable),
        .sdata_in   (sdata_in),
        .frame_sync (frame_sync),
        .err_clr    (err_clr),
        .data16     (data16),
        .read       (read),
        .frame_err  (frame_err),
        .word_cnt   (word_cnt)
    );

    always #5 data_clk = ~data_clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock edge; outputs sampled 1 time unit later, read strobes scored.
    task automatic tick();
        logic [15:0] exp_word;
        @(posedge data_clk);
        #1;
        cyc++;
        if (read === 1'b1) begin
            reads_seen++;
            read_gap      = cyc - last_read_cyc;
            last_read_cyc = cyc;
            check("read_one_cycle", 32'(prev_read), 0);
            check("read_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_word = sb.pop_front();
                check("data16", 32'(data16), 32'(exp_word));
            end
        end
        prev_read = read;
    endtask

    task automatic send_bit(input logic sync, input logic b);
        frame_sync = sync;
        sdata_in   = b;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] word, input logic push);
        if (push) sb.push_back(word);
        for (int i = 15; i >= 0; i--) send_bit(i == 15, word[i]);
    endtask

    task automatic reset_dut();
        reset = 1'b1; enable = 1'b0; frame_sync = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge data_clk);
        #1;
        reset = 1'b0;
        sb.delete();
        prev_read = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        // Reset state
        reset_dut();
        check("rst_data16", 32'(data16), 0);
        check("rst_read", 32'(read), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_word_cnt", 32'(word_cnt), 0);

        // Single frame
        reads0 = reads_seen;
        send_frame(16'h2A5C, 1'b1);
        check("single_read_cnt", 32'(reads_seen - reads0), 1);
        check("single_word_cnt", 32'(word_cnt), 1);
        send_bit(1'b0, 1'b0);
        check("single_read_fall", 32'(read), 0);
        check("single_data16_hold", 32'(data16), 32'h2A5C);

        // Back-to-back frames
        reset_dut();
        reads0 = reads_seen;
        send_frame(16'hFFFF, 1'b1);
        send_frame(16'h0000, 1'b1);
        send_frame(16'h2222, 1'b1);
        check("b2b_read_cnt", 32'(reads_seen - reads0), 3);
        check("b2b_gap", 32'(read_gap), 16);
        check("b2b_word_cnt", 32'(word_cnt), 3);
        check("b2b_frame_err", 32'(frame_err), 0);
        send_bit(1'b0, 1'b0);

        // Early sync seven bits into a frame
        reset_dut();
        reads0 = reads_seen;
        for (int i = 0; i < 7; i++) send_bit(i == 0, 1'b1);
        send_frame(16'h1234, 1'b1);
        check("early_frame_err", 32'(frame_err), 1);
        check("early_read_cnt", 32'(reads_seen - reads0), 1);
        check("early_data16", 32'(data16), 32'h1234);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("early_err_clr", 32'(frame_err), 0);

        // Clear and early sync on the same edge
        reads0 = reads_seen;
        send_bit(1'b1, 1'b0);
        repeat (3) send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        check("simul_first_set", 32'(frame_err), 1);
        repeat (2) send_bit(1'b0, 1'b1);
        err_clr = 1'b1;
        send_bit(1'b1, 1'b1);
        err_clr = 1'b0;
        check("simul_set_wins", 32'(frame_err), 1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        check("simul_abort_keeps_err", 32'(frame_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("simul_cleared", 32'(frame_err), 0);
        check("simul_no_read", 32'(reads_seen - reads0), 0);

        // Enable dropped after nine bits, then a clean frame
        reads0 = reads_seen;
        for (int i = 15; i >= 7; i--) send_bit(i == 15, i[0]);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        send_frame(16'hBEEF, 1'b1);
        check("abort_read_cnt", 32'(reads_seen - reads0), 1);
        check("abort_frame_err", 32'(frame_err), 0);
        check("abort_data16", 32'(data16), 32'hBEEF);
        check("abort_word_cnt", 32'(word_cnt), 2);

        // Reset mid-frame with frame_err and data16 non-zero
        send_bit(1'b1, 1'b1);
        repeat (3) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        repeat (3) send_bit(1'b0, 1'b1);
        check("pre_reset_err", 32'(frame_err), 1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_data16", 32'(data16), 0);
        check("async_rst_read", 32'(read), 0);
        check("async_rst_err", 32'(frame_err), 0);
        check("async_rst_word_cnt", 32'(word_cnt), 0);
        @(posedge data_clk);
        #1;
        reset = 1'b0;
        prev_read = 1'b0;
        sb.delete();
        reads0 = reads_seen;
        for (int i = 0; i < 20; i++) send_bit(1'b0, 1'($urandom));
        check("post_rst_no_read", 32'(reads_seen - reads0), 0);
        send_frame(16'hC3A5, 1'b1);
        check("post_rst_word_cnt", 32'(word_cnt), 1);

        // 256-frame run: counter wraps to zero
        reset_dut();
        reads0 = reads_seen;
        for (int n = 0; n < 255; n++) send_frame(16'($urandom), 1'b1);
        check("wrap_cnt_255", 32'(word_cnt), 255);
        send_frame(16'h5A5A, 1'b1);
        check("wrap_cnt_0", 32'(word_cnt), 0);
        check("wrap_read_cnt", 32'(reads_seen - reads0), 256);
        check("wrap_gap", 32'(read_gap), 16);
        send_bit(1'b0, 1'b0);
        check("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_word_receiver

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-to-parallel front end for the ADC readout path, clocked by `data_clk`. It assembles MSB-first bits on `sdata_in` into 16-bit frames delimited by `frame_sync`. For each complete frame it presents the word on `data16` and issues a single-cycle `read` strobe to the downstream 16-to-4 channel-bit deserializer. It also flags framing faults and counts delivered words for the status register block.

## Interface
- `WORD_BITS`, 16: frame length in bits; only 16 is supported by the downstream stage.
- `CNT_W`, 8: width of `word_cnt`.
- `data_clk` in 1: bit clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clock `data_clk`.
- `enable` in 1: capture enable; low aborts any frame in progress.
- `sdata_in` in 1: serial data, sampled on every rising edge of `data_clk`.
- `frame_sync` in 1: high for exactly the cycle carrying bit 15 (MSB) of a frame.
- `err_clr` in 1: single-cycle clear for `frame_err`.
- `data16` out 16: last complete word; holds until the next completion.
- `read` out 1: one-cycle strobe, high for the cycle after the 16th bit is sampled.
- `frame_err` out 1: sticky framing-fault flag.
- `word_cnt` out CNT_W: number of `read` strobes, modulo 2^CNT_W.

## Operation
- States are IDLE and SHIFT; `bit_cnt` is 4 bits wide and `shreg` is 15 bits wide.
- IDLE:
  - On an edge with `enable` and `frame_sync` high: `shreg[0] <= sdata_in`, `bit_cnt <= 1`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, per edge with `enable` high:
  - If `frame_sync` is high and `bit_cnt` is 1..15: this is an early sync. Set `frame_err`. Discard the partial word and restart the frame with the current bit (`shreg[0] <= sdata_in`, `bit_cnt <= 1`). No `read` is issued.
  - Else if `bit_cnt` is 15: this is the last bit.
    - `data16 <= {shreg[14:0], sdata_in}`
    - `read <= 1`
    - `word_cnt <= word_cnt + 1`, wrapping
    - go to IDLE
  - Else: `shreg <= {shreg[13:0], sdata_in}`, `bit_cnt <= bit_cnt + 1`.
- Back-to-back frames: on the edge following the last bit, the block is in IDLE. A `frame_sync` on that edge is accepted normally, giving continuous 16-cycle frames.
- `enable` low in SHIFT: return to IDLE on that edge. The partial word is dropped silently; no error and no `read`.
- `frame_err`:
  - Set only by an early sync.
  - Cleared by `err_clr` when no set occurs on the same edge.
  - A set and a clear on the same edge leave the flag set.
- `read` is deasserted on every edge except the completion edge.
- `data16` and `word_cnt` change only on the completion edge.
- Reset values: state IDLE; `shreg`, `bit_cnt`, `data16`, `word_cnt` all 0; `read` 0; `frame_err` 0.
- Reset mid-frame returns to IDLE immediately; the partial word is lost.

## Timing
- `frame_sync` sampled at edge k means bits 15..0 are sampled at edges k..k+15.
- `data16` and `read` become valid after edge k+15. `read` falls after edge k+16.
- Latency from the MSB sample to `read` is 15 cycles, plus one register edge.
- `data16` is stable for at least 16 cycles after `read`. This covers the downstream capture window, which is the `read` cycle plus 2 cycles.
- Minimum `read` spacing is 16 cycles.
- `frame_err` is visible the cycle after the offending edge.

## Structure
- Shared definitions file `eeg_fe_defs.vh`: `WORD_BITS`, state encodings `ST_IDLE` and `ST_SHIFT`, and the `CNT_W` default.
- Optional sub-module `sticky_flag`: set/clear register with set priority, reused by the status logic.
- All other logic is flat in this module.

## Test plan
- Single frame: sync at edge 0 with stream 0x2A5C MSB-first. Required: `data16`=0x2A5C after edge 15, `read` high exactly one cycle, `word_cnt`=1.
- Back-to-back: three contiguous frames 0xFFFF, 0x0000, 0x2222, each sync 16 cycles apart. Required: three `read` strobes spaced 16 cycles apart with matching `data16`, `word_cnt`=3, `frame_err`=0.
- Early sync: second sync 7 bits into a frame, followed by a full 0x1234 frame. Required: `frame_err`=1, one `read` only, `data16`=0x1234. `err_clr` then returns `frame_err` to 0.
- Simultaneous `err_clr` and early sync on the same edge. Required: `frame_err` remains 1.
- `enable` dropped at bit 9, then re-raised with a new 0xBEEF frame. Required: no `read` for the aborted frame, `frame_err`=0, `data16`=0xBEEF.
- Reset asserted mid-frame, and a 256-frame run. Required: after reset all outputs are 0 and no `read` is issued until the next sync. After 256 frames `word_cnt` wraps to 0.
